rapid_dmem_responder: RTL and testbench

Data-memory responder that serves the load/store requests issued by the core's MEM stage. It accepts one request at a time over a valid/ready handshake and decodes the RV32I load/store funct3 codes. It performs byte/halfword/word writes with byte enables, and returns sign- or zero-extended load data together with the destination register after a programmable number of wait states. It sits between the MEM stage and the WB register, as the data-side counterpart of the MEM-stage request logic.

---
 rtl/rapid_dmem_responder.sv | 193 +++++++++++++++++++
 tb/tb_rapid_dmem_responder.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rapid_dmem_responder.sv
// Data-memory responder for the MEM stage: one load/store at a time, programmable
// wait states, byte-enable writes and sign/zero-extended load data with error flagging.
module rapid_dmem_responder #(
    parameter int XLEN        = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic            req_we_i,
    input  logic [2:0]      req_funct3_i,
    input  logic [XLEN-1:0] req_addr_i,
    input  logic [XLEN-1:0] req_wdata_i,
    input  logic [4:0]      req_rd_i,
    output logic            resp_valid_o,
    input  logic            resp_ready_i,
    output logic [XLEN-1:0] resp_rdata_o,
    output logic [4:0]      resp_rd_o,
    output logic            resp_err_o
);

    localparam int         AW       = $clog2(DEPTH_WORDS);
    localparam bit         NO_WAIT  = (WAIT_STATES == 0);
    localparam logic [3:0] CNT_INIT = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            accept, commit;

    logic            we_q;
    logic [2:0]      funct3_q;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] wdata_q;
    logic [4:0]      rd_q;

    logic [XLEN-1:0] rdata_q;
    logic [4:0]      resp_rd_q;
    logic            err_q;

    logic [31:0]     mem_q [DEPTH_WORDS];

    // With no wait states the commit happens on the accept edge, so the
    // request fields come straight from the inputs rather than the latches.
    logic            c_we;
    logic [2:0]      c_f3;
    logic [XLEN-1:0] c_addr;
    logic [XLEN-1:0] c_wdata;
    logic [4:0]      c_rd;
    logic [AW-1:0]   c_idx;
    logic            c_err;
    logic [3:0]      be;
    logic [31:0]     wr_data;
    logic [31:0]     rd_word;
    logic [7:0]      rd_byte;
    logic [15:0]     rd_half;
    logic [XLEN-1:0] ld_data;
    logic            commit_wr;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        commit  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    accept = 1'b1;
                    if (NO_WAIT) begin
                        state_d = S_RESP;
                        commit  = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_RESP;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                if (resp_ready_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        c_we    = (state_q == S_IDLE) ? req_we_i     : we_q;
        c_f3    = (state_q == S_IDLE) ? req_funct3_i : funct3_q;
        c_addr  = (state_q == S_IDLE) ? req_addr_i   : addr_q;
        c_wdata = (state_q == S_IDLE) ? req_wdata_i  : wdata_q;
        c_rd    = (state_q == S_IDLE) ? req_rd_i     : rd_q;
        c_idx   = c_addr[AW+1:2];
    end

    always_comb begin
        if (c_we) c_err = !(c_f3 inside {3'b000, 3'b001, 3'b010});
        else      c_err = !(c_f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        if (c_f3[1:0] == 2'b01 && c_addr[0])           c_err = 1'b1;
        if (c_f3[1:0] == 2'b10 && c_addr[1:0] != 2'b00) c_err = 1'b1;
        if (|c_addr[XLEN-1:AW+2])                      c_err = 1'b1;
    end

    always_comb begin
        be      = 4'b0000;
        wr_data = c_wdata;
        case (c_f3[1:0])
            2'b00: begin
                be      = 4'b0001 << c_addr[1:0];
                wr_data = {4{c_wdata[7:0]}};
            end
            2'b01: begin
                be      = c_addr[1] ? 4'b1100 : 4'b0011;
                wr_data = {2{c_wdata[15:0]}};
            end
            2'b10:   be = 4'b1111;
            default: be = 4'b0000;
        endcase
    end

    always_comb begin
        rd_word = mem_q[c_idx];
        rd_byte = rd_word[{c_addr[1:0], 3'b000} +: 8];
        rd_half = c_addr[1] ? rd_word[31:16] : rd_word[15:0];
        case (c_f3)
            3'b000:  ld_data = {{24{rd_byte[7]}}, rd_byte};
            3'b001:  ld_data = {{16{rd_half[15]}}, rd_half};
            3'b010:  ld_data = rd_word;
            3'b100:  ld_data = {24'd0, rd_byte};
            3'b101:  ld_data = {16'd0, rd_half};
            default: ld_data = '0;
        endcase
    end

    assign commit_wr = commit && !rst_i && c_we && !c_err;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            cnt_q     <= 4'd0;
            rdata_q   <= '0;
            resp_rd_q <= 5'd0;
            err_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (commit) begin
                err_q     <= c_err;
                rdata_q   <= (!c_we && !c_err) ? ld_data : '0;
                resp_rd_q <= (!c_we && !c_err) ? c_rd : 5'd0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (accept) begin
            we_q     <= req_we_i;
            funct3_q <= req_funct3_i;
            addr_q   <= req_addr_i;
            wdata_q  <= req_wdata_i;
            rd_q     <= req_rd_i;
        end
    end

    // Storage has no reset; only lanes with an enable are touched.
    always_ff @(posedge clk_i) begin
        if (commit_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem_q[c_idx][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
    end

    assign req_ready_o  = (state_q == S_IDLE);
    assign resp_valid_o = (state_q == S_RESP);
    assign resp_rdata_o = rdata_q;
    assign resp_rd_o    = resp_rd_q;
    assign resp_err_o   = err_q;

endmodule

// File: tb/tb_rapid_dmem_responder.sv
// Scoreboard bench for rapid_dmem_responder: a WAIT_STATES=1 instance for the
// main traffic and a WAIT_STATES=3 instance for the mid-transaction reset case.
module tb_rapid_dmem_responder;

    localparam int DEPTH = 1024;
    localparam int WS    = 1;
    localparam int WS3   = 3;

    typedef struct packed {
        logic [31:0] rdata;
        logic [4:0]  rd;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, req_valid, req_ready, req_we, resp_valid, resp_ready, resp_err;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata, resp_rdata;
    logic [4:0]  req_rd, resp_rd;

    logic        rst3, req_valid3, req_ready3, req_we3, resp_valid3, resp_ready3, resp_err3;
    logic [2:0]  req_funct3_3;
    logic [31:0] req_addr3, req_wdata3, resp_rdata3;
    logic [4:0]  req_rd3, resp_rd3;

    exp_t        sb[$];
    exp_t        mon_e;
    logic [31:0] mdl [DEPTH];
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    rapid_dmem_responder #(.XLEN(32), .DEPTH_WORDS(DEPTH), .WAIT_STATES(WS)) u_dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
        .req_funct3_i(req_funct3), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .req_rd_i(req_rd), .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
        .resp_rdata_o(resp_rdata), .resp_rd_o(resp_rd), .resp_err_o(resp_err)
    );

    rapid_dmem_responder #(.XLEN(32), .DEPTH_WORDS(DEPTH), .WAIT_STATES(WS3)) u_dut3 (
        .clk_i(clk), .rst_i(rst3),
        .req_valid_i(req_valid3), .req_ready_o(req_ready3), .req_we_i(req_we3),
        .req_funct3_i(req_funct3_3), .req_addr_i(req_addr3), .req_wdata_i(req_wdata3),
        .req_rd_i(req_rd3), .resp_valid_o(resp_valid3), .resp_ready_i(resp_ready3),
        .resp_rdata_o(resp_rdata3), .resp_rd_o(resp_rd3), .resp_err_o(resp_err3)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference model: computes the expected response and applies stores.
    task automatic push_exp(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [4:0] rd);
        exp_t        e;
        logic        bad;
        logic [31:0] w;
        logic [7:0]  b;
        logic [15:0] h;
        int          idx;
        int          sh;
        bad = we ? !(f3 inside {3'd0, 3'd1, 3'd2}) : !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        if (f3[1:0] == 2'd1 && addr[0])          bad = 1'b1;
        if (f3[1:0] == 2'd2 && addr[1:0] != 2'd0) bad = 1'b1;
        if (addr[31:2] >= 30'(DEPTH))            bad = 1'b1;
        e     = '0;
        e.err = bad;
        if (!bad) begin
            idx = int'(addr[31:2]);
            w   = mdl[idx];
            if (we) begin
                if (f3 == 3'd0) begin
                    sh = 8 * int'(addr[1:0]);
                    w  = (w & ~(32'h0000_00FF << sh)) | ({24'd0, wdata[7:0]} << sh);
                end else if (f3 == 3'd1) begin
                    sh = addr[1] ? 16 : 0;
                    w  = (w & ~(32'h0000_FFFF << sh)) | ({16'd0, wdata[15:0]} << sh);
                end else begin
                    w = wdata;
                end
                mdl[idx] = w;
            end else begin
                b    = 8'(w >> (8 * int'(addr[1:0])));
                h    = 16'(w >> (addr[1] ? 16 : 0));
                e.rd = rd;
                case (f3)
                    3'd0:    e.rdata = {{24{b[7]}}, b};
                    3'd1:    e.rdata = {{16{h[15]}}, h};
                    3'd4:    e.rdata = {24'd0, b};
                    3'd5:    e.rdata = {16'd0, h};
                    default: e.rdata = w;
                endcase
            end
        end
        sb.push_back(e);
    endtask

    task automatic drive_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [4:0] rd);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        req_rd     = rd;
    endtask

    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [4:0] rd);
        int n;
        int lat;
        push_exp(we, f3, addr, wdata, rd);
        drive_req(we, f3, addr, wdata, rd);
        n = 0;
        while (!req_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        check_eq("req_ready_idle", req_ready, 1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_wdata = $urandom;
        req_rd    = 5'($urandom);
        lat = 1;
        while (!resp_valid && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        check_eq("latency", lat, WS + 1);
        @(posedge clk); #1;
    endtask

    task automatic u3_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [4:0] rd, output logic [31:0] o_data,
                          output logic [4:0] o_rd, output logic o_err);
        int lat;
        req_valid3   = 1'b1;
        req_we3      = we;
        req_funct3_3 = 3'b010;
        req_addr3    = addr;
        req_wdata3   = wdata;
        req_rd3      = rd;
        @(posedge clk); #1;
        req_valid3 = 1'b0;
        lat = 1;
        while (!resp_valid3 && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        check_eq("u3_latency", lat, WS3 + 1);
        o_data = resp_rdata3;
        o_rd   = resp_rd3;
        o_err  = resp_err3;
        @(posedge clk); #1;
    endtask

    always @(negedge clk) begin
        if (!rst && resp_valid && resp_ready) begin
            if (sb.size() == 0) begin
                check_eq("sb_unexpected_resp", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                check_eq("resp_rdata", resp_rdata, mon_e.rdata);
                check_eq("resp_rd", resp_rd, mon_e.rd);
                check_eq("resp_err", resp_err, mon_e.err);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] d3;
        logic [4:0]  r3;
        logic        e3;
        int          stray;
        int          n;

        for (int i = 0; i < DEPTH; i++) mdl[i] = 32'd0;
        rst = 1'b1; rst3 = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0; req_addr = '0; req_wdata = '0; req_rd = '0;
        req_valid3 = 1'b0; req_we3 = 1'b0; req_funct3_3 = 3'd0; req_addr3 = '0; req_wdata3 = '0; req_rd3 = '0;
        resp_ready = 1'b1; resp_ready3 = 1'b1;

        @(posedge clk); #1;
        check_eq("rst_req_ready", req_ready, 1);
        check_eq("rst_resp_valid", resp_valid, 0);
        check_eq("rst_resp_rdata", resp_rdata, 0);
        check_eq("rst_resp_rd", resp_rd, 0);
        check_eq("rst_resp_err", resp_err, 0);
        check_eq("rst3_req_ready", req_ready3, 1);
        @(posedge clk); #1;
        rst = 1'b0; rst3 = 1'b0;

        do_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 5'd0);
        do_req(1'b0, 3'b010, 32'h10, 32'h0, 5'd5);

        do_req(1'b1, 3'b010, 32'h20, 32'h80FF7F01, 5'd0);
        do_req(1'b0, 3'b000, 32'h21, 32'h0, 5'd1);
        do_req(1'b0, 3'b000, 32'h22, 32'h0, 5'd2);
        do_req(1'b0, 3'b100, 32'h22, 32'h0, 5'd3);
        do_req(1'b0, 3'b001, 32'h22, 32'h0, 5'd4);
        do_req(1'b0, 3'b101, 32'h22, 32'h0, 5'd6);
        do_req(1'b1, 3'b000, 32'h23, 32'h12, 5'd0);
        do_req(1'b0, 3'b010, 32'h20, 32'h0, 5'd8);

        do_req(1'b1, 3'b010, 32'h30, 32'hCAFEF00D, 5'd0);
        do_req(1'b1, 3'b010, 32'h00, 32'h11223344, 5'd0);
        do_req(1'b0, 3'b001, 32'h31, 32'h0, 5'd9);
        do_req(1'b1, 3'b010, 32'h32, 32'hFFFFFFFF, 5'd0);
        do_req(1'b0, 3'b011, 32'h30, 32'h0, 5'd10);
        do_req(1'b1, 3'b010, 32'(4 * DEPTH), 32'hA5A5A5A5, 5'd0);
        do_req(1'b0, 3'b010, 32'h30, 32'h0, 5'd11);
        do_req(1'b0, 3'b010, 32'h00, 32'h0, 5'd12);
        do_req(1'b1, 3'b001, 32'h32, 32'h0000BEEF, 5'd0);
        do_req(1'b0, 3'b010, 32'h30, 32'h0, 5'd14);

        // Backpressure: response must hold and new requests must be ignored.
        resp_ready = 1'b0;
        push_exp(1'b0, 3'b010, 32'h10, 32'h0, 5'd13);
        drive_req(1'b0, 3'b010, 32'h10, 32'h0, 5'd13);
        @(posedge clk); #1;
        req_valid = 1'b0;
        n = 0;
        while (!resp_valid && n < 40) begin
            @(posedge clk); #1; n++;
        end
        for (int k = 0; k < 5; k++) begin
            drive_req(1'b1, 3'b010, 32'h10, 32'hBAD0BAD0, 5'd0);
            check_eq("bp_resp_valid", resp_valid, 1);
            check_eq("bp_resp_rdata", resp_rdata, 32'hDEADBEEF);
            check_eq("bp_resp_rd", resp_rd, 13);
            check_eq("bp_req_ready", req_ready, 0);
            @(posedge clk); #1;
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        check_eq("bp_req_ready_after", req_ready, 1);
        check_eq("bp_resp_valid_after", resp_valid, 0);
        do_req(1'b0, 3'b010, 32'h10, 32'h0, 5'd15);

        // Reset during the second wait cycle drops the store.
        u3_req(1'b1, 32'h40, 32'h0, 5'd0, d3, r3, e3);
        check_eq("u3_prewrite_err", e3, 0);
        req_valid3   = 1'b1;
        req_we3      = 1'b1;
        req_funct3_3 = 3'b010;
        req_addr3    = 32'h40;
        req_wdata3   = 32'h55;
        @(posedge clk); #1;
        req_valid3 = 1'b0;
        @(posedge clk); #1;
        rst3 = 1'b1;
        @(posedge clk); #1;
        rst3 = 1'b0;
        check_eq("u3_rst_req_ready", req_ready3, 1);
        check_eq("u3_rst_resp_valid", resp_valid3, 0);
        stray = 0;
        for (int k = 0; k < 6; k++) begin
            if (resp_valid3) stray++;
            @(posedge clk); #1;
        end
        check_eq("u3_stray_resp", stray, 0);
        u3_req(1'b0, 32'h40, 32'h0, 5'd7, d3, r3, e3);
        check_eq("u3_lw_rdata", d3, 32'h0);
        check_eq("u3_lw_rd", r3, 7);
        check_eq("u3_lw_err", e3, 0);

        repeat (3) @(posedge clk);
        #1;
        check_eq("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
